// File: rtl/fp_addsub_param_if.sv
// Operand/result bundle for fp_addsub_param: request side driven by the master,
// result and status returned by the slave (the arithmetic unit).
interface fp_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done_tick;
    logic [W-1:0] o;
    logic         nan;
    logic         inf;
    logic         ovf;
    logic         inexact;

    modport master (
        output start, op, a, b,
        input  busy, done_tick, o, nan, inf, ovf, inexact
    );

    modport slave (
        input  start, op, a, b,
        output busy, done_tick, o, nan, inf, ovf, inexact
    );
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle parameterised floating-point adder/subtractor, fixed 6-cycle latency.
// Define FP_ADDSUB_SUBNORM_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset_n,
    fp_addsub_param_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EXT_W = MAN_W + 4;  // {hidden, fraction, guard, round, sticky}
    localparam int XE_W  = EXP_W + 1;  // headroom for the two possible +1 steps
    localparam logic [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, EXC, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, o_q, o_d;
    logic             op_q, op_d, exc_q, exc_d, exc_nan_q, exc_nan_d;
    logic             sign_q, sign_d, sub_q, sub_d;
    logic [XE_W-1:0]  exp_q, exp_d, diff_q, diff_d;
    logic [EXT_W-1:0] sig_x_q, sig_x_d, sig_y_q, sig_y_d;
    logic [EXT_W:0]   sum_q, sum_d;
    logic             nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d, inexact_q, inexact_d;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [XE_W-1:0]  ea, eb, exp_r;
    logic [EXT_W-1:0] sig_a, sig_b;
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, lost, round_up, flush;
    logic [MAN_W+1:0] rnd;
    int               sh, lzc, lim, lsh;

    // Operand unpacking; a zero exponent is always treated as exponent 1 so the
    // alignment and normalisation arithmetic never has to special-case it.
    always_comb begin
        exp_a = a_q[W-2 -: EXP_W];
        exp_b = b_q[W-2 -: EXP_W];
        sa    = a_q[W-1];
        sb    = b_q[W-1] ^ op_q;
        a_nan = (&exp_a) && (|a_q[MAN_W-1:0]);
        b_nan = (&exp_b) && (|b_q[MAN_W-1:0]);
        a_inf = (&exp_a) && !(|a_q[MAN_W-1:0]);
        b_inf = (&exp_b) && !(|b_q[MAN_W-1:0]);
        ea    = (exp_a == '0) ? XE_W'(1) : XE_W'(exp_a);
        eb    = (exp_b == '0) ? XE_W'(1) : XE_W'(exp_b);
`ifdef FP_ADDSUB_SUBNORM_EN
        sig_a = {(exp_a != '0), a_q[MAN_W-1:0], 3'b000};
        sig_b = {(exp_b != '0), b_q[MAN_W-1:0], 3'b000};
`else
        sig_a = (exp_a != '0) ? {1'b1, a_q[MAN_W-1:0], 3'b000} : '0;
        sig_b = (exp_b != '0) ? {1'b1, b_q[MAN_W-1:0], 3'b000} : '0;
`endif
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        exc_d     = exc_q;
        exc_nan_d = exc_nan_q;
        sign_d    = sign_q;
        sub_d     = sub_q;
        exp_d     = exp_q;
        diff_d    = diff_q;
        sig_x_d   = sig_x_q;
        sig_y_d   = sig_y_q;
        sum_d     = sum_q;
        o_d       = o_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;
        sh        = 0;
        lost      = 1'b0;
        lzc       = EXT_W;
        lim       = 0;
        lsh       = 0;
        round_up  = 1'b0;
        rnd       = '0;
        exp_r     = exp_q;
        flush     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    state_d = EXC;
                end
            end
            EXC: begin
                sub_d = sa ^ sb;
                // Order by magnitude so ADD never produces a negative difference.
                if ({eb, sig_b} > {ea, sig_a}) begin
                    sign_d = sb; exp_d = eb; sig_x_d = sig_b; sig_y_d = sig_a; diff_d = eb - ea;
                end else begin
                    sign_d = sa; exp_d = ea; sig_x_d = sig_a; sig_y_d = sig_b; diff_d = ea - eb;
                end
                exc_d     = 1'b0;
                exc_nan_d = 1'b0;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    exc_d     = 1'b1;
                    exc_nan_d = 1'b1;
                end else if (a_inf || b_inf) begin
                    exc_d  = 1'b1;
                    sign_d = a_inf ? sa : sb;
                end
                state_d = ALIGN;
            end
            ALIGN: begin
                sh      = (int'(diff_q) > MAN_W + 3) ? MAN_W + 3 : int'(diff_q);
                lost    = |(sig_y_q & ~({EXT_W{1'b1}} << sh));
                sig_y_d = (sig_y_q >> sh) | EXT_W'(lost);
                state_d = ADD;
            end
            ADD: begin
                if (sub_q) sum_d = {1'b0, sig_x_q} - {1'b0, sig_y_q};
                else       sum_d = {1'b0, sig_x_q} + {1'b0, sig_y_q};
                if (sub_q && (sum_d == '0)) sign_d = 1'b0;
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[EXT_W]) begin
                    sig_x_d = {sum_q[EXT_W:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + XE_W'(1);
                end else begin
                    for (int i = 0; i < EXT_W; i++) begin
                        if (sum_q[i]) lzc = EXT_W - 1 - i;
                    end
                    lim     = int'(exp_q) - 1;
                    lsh     = (lzc < lim) ? lzc : lim;
                    sig_x_d = sum_q[EXT_W-1:0] << lsh;
                    exp_d   = exp_q - XE_W'(lsh);
                end
                state_d = ROUND;
            end
            ROUND: begin
                round_up = sig_x_q[2] && (sig_x_q[1] || sig_x_q[0] || sig_x_q[3]);
                rnd      = {1'b0, sig_x_q[EXT_W-1:3]} + (MAN_W+2)'(round_up);
                if (rnd[MAN_W+1]) begin
                    rnd   = rnd >> 1;
                    exp_r = exp_q + XE_W'(1);
                end
`ifdef FP_ADDSUB_SUBNORM_EN
                flush = 1'b0;
`else
                flush = !sig_x_q[EXT_W-1] && (sig_x_q != '0);
`endif
                nan_d     = 1'b0;
                inf_d     = 1'b0;
                ovf_d     = 1'b0;
                inexact_d = |sig_x_q[2:0];
                if (exc_q) begin
                    nan_d     = exc_nan_q;
                    inf_d     = !exc_nan_q;
                    inexact_d = 1'b0;
                    o_d = exc_nan_q ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
                                    : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (exp_r >= EXP_MAX) begin
                    inf_d     = 1'b1;
                    ovf_d     = 1'b1;
                    inexact_d = 1'b1;
                    o_d       = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (flush) begin
                    inexact_d = 1'b1;
                    o_d       = {sign_q, {(W-1){1'b0}}};
                end else begin
                    // A clear hidden bit after normalisation means a subnormal encoding.
                    o_d = {sign_q, rnd[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, rnd[MAN_W-1:0]};
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // datapath included, is reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            exc_q     <= 1'b0;
            exc_nan_q <= 1'b0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            exp_q     <= '0;
            diff_q    <= '0;
            sig_x_q   <= '0;
            sig_y_q   <= '0;
            sum_q     <= '0;
            o_q       <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            exc_q     <= exc_d;
            exc_nan_q <= exc_nan_d;
            sign_q    <= sign_d;
            sub_q     <= sub_d;
            exp_q     <= exp_d;
            diff_q    <= diff_d;
            sig_x_q   <= sig_x_d;
            sig_y_q   <= sig_y_d;
            sum_q     <= sum_d;
            o_q       <= o_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.o         = o_q;
    assign bus.nan       = nan_q;
    assign bus.inf       = inf_q;
    assign bus.ovf       = ovf_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed bench for fp_addsub_param (single precision); expected results are queued
// at issue time and popped when done_tick appears.
module tb_fp_addsub_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [W-1:0] o;
        logic [3:0]   flags;  // {nan, inf, ovf, inexact}
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   saw_done;

    fp_addsub_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.nan, bus.inf, bus.ovf, bus.inexact};
    endfunction

    // Issue one operation; inputs are scrambled right after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input logic [W-1:0] eo, input logic [3:0] ef);
        sb_q.push_back('{o: eo, flags: ef});
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.op = top; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~ta; bus.b = ~tb_v; bus.op = ~top;
        check("accept_busy", 64'(bus.busy), 64'd1);
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                lat = k;
                break;
            end
            check({tag, "_busy_wait"}, 64'(bus.busy), 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_o"}, 64'(bus.o), 64'(e.o));
            check({tag, "_flags"}, 64'(flags_now()), 64'(e.flags));
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 64'(bus.done_tick), 64'd0);
            check({tag, "_idle"}, 64'(bus.busy), 64'd0);
            check({tag, "_o_hold"}, 64'(bus.o), 64'(e.o));
        end else begin
            check({tag, "_sb_underflow"}, 64'(sb_q.size()), 64'd1);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o", 64'(bus.o), 64'd0);
        check("rst_flags", 64'(flags_now()), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done_tick), 64'd0);
        reset_n = 1'b1;

        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000); collect("one_plus_one", 5);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); collect("one_minus_one", 5);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000); collect("inf_minus_inf", 5);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0111); collect("max_overflow", 5);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); collect("tie_even", 5);
        send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001); collect("above_tie", 5);
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0100); collect("inf_plus_one", 5);
        send(32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0100); collect("neg_inf_sum", 5);
        send(32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000); collect("nan_in", 5);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); collect("neg_zero_sum", 5);
        send(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000); collect("mixed_zero", 5);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000); collect("three_minus_one", 5);
        send(32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000); collect("cancel_shift", 5);
`ifdef FP_ADDSUB_SUBNORM_EN
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000); collect("subnorm_add", 5);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000); collect("underflow_sub", 5);
`else
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000); collect("subnorm_add", 5);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0001); collect("underflow_sub", 5);
`endif

        // A second start while in ALIGN must be ignored.
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        bus.a = 32'h40400000; bus.b = 32'h40400000; bus.op = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        collect("start_in_align", 3);
        @(posedge clk); #1;
        check("no_second_op", 64'(bus.busy), 64'd0);

        // Reset during NORM aborts the operation without a done_tick.
        @(negedge clk);
        bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_o", 64'(bus.o), 64'd0);
        check("abort_flags", 64'(flags_now()), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        saw_done = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (bus.done_tick) saw_done = 1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        // Start is already high when reset releases; the first edge must accept it.
        sb_q.push_back('{o: 32'h3FC00000, flags: 4'b0000});
        @(negedge clk);
        bus.a = 32'h3F800000; bus.b = 32'h3F000000; bus.op = 1'b0; bus.start = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("post_rst_accept", 64'(bus.busy), 64'd1);
        collect("post_rst", 5);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
